key_input_cond: RTL and testbench

Input-conditioning stage for the DE2 push buttons, sitting between the raw KEY pins and the single-cycle core's memory-mapped input port. Each key is synchronised, debounced with a per-key counter state machine and polarity-normalised. The block publishes a clean level per key plus one-cycle press and release pulses, so firmware and core I/O logic never see bounce or metastability.

---
 rtl/key_input_cond_pkg.sv | 20 ++
 rtl/key_input_cond_debounce_cell.sv | 137 +++++++++++++
 rtl/key_input_cond.sv | 52 +++++
 tb/tb_key_input_cond.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/key_input_cond_pkg.sv
// Shared types and constants for the push-button conditioning block.
package key_input_cond_pkg;

  typedef enum logic [1:0] {
    STABLE_OFF = 2'd0,
    WAIT_ON    = 2'd1,
    STABLE_ON  = 2'd2,
    WAIT_OFF   = 2'd3
  } key_state_e;

  // 20 ms at 50 MHz.
  localparam int DEBOUNCE_CYCLES_DEF = 1000000;
  localparam int DEBOUNCE_CYCLES_SIM = 8;

  // Raw pin level of a released button.
  function automatic logic raw_idle_level(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/key_input_cond_debounce_cell.sv
// One key channel: 2-flop synchroniser, polarity fix, debounce FSM and counter.
// KEY_INPUT_COND_DEBOUNCE_BYPASS_EN replaces the FSM with a single level register.
module key_debounce_cell
  import key_input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_press_nxt
);

  localparam logic RAW_IDLE = raw_idle_level(ACTIVE_LOW);

  logic r_sync1, r_sync2;
  logic w_s;
  logic r_level, r_press, r_release;
  logic w_level_nxt, w_press_nxt, w_release_nxt;

  // Synchroniser resets to the released pin level so reset itself never looks like a press.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= RAW_IDLE;
      r_sync2 <= RAW_IDLE;
    end else begin
      // NOTE: non-blocking so r_sync2 takes the old r_sync1, giving two real flop stages.
      r_sync1 <= i_key_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2 ^ ACTIVE_LOW;

`ifdef KEY_INPUT_COND_DEBOUNCE_BYPASS_EN

  always_comb begin
    w_level_nxt   = w_s;
    w_press_nxt   = w_s & ~r_level;
    w_release_nxt = ~w_s & r_level;
  end

`else

  localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  key_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_level_nxt   = r_level;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    case (r_state)
      STABLE_OFF: begin
        if (w_s) begin
          w_state_nxt = WAIT_ON;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_ON: begin
        if (!w_s) begin
          w_state_nxt = STABLE_OFF;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = STABLE_ON;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b1;
          w_press_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      STABLE_ON: begin
        if (!w_s) begin
          w_state_nxt = WAIT_OFF;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_OFF: begin
        if (w_s) begin
          w_state_nxt = STABLE_ON;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt   = STABLE_OFF;
          w_cnt_nxt     = '0;
          w_level_nxt   = 1'b0;
          w_release_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = STABLE_OFF;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= STABLE_OFF;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  assign o_level     = r_level;
  assign o_press     = r_press;
  assign o_release   = r_release;
  assign o_press_nxt = w_press_nxt;

endmodule

// File: rtl/key_input_cond.sv
// KEY conditioning top: NUM_KEYS independent debounce cells plus a registered any-press flag.
// Build option KEY_INPUT_COND_DEBOUNCE_BYPASS_EN skips debouncing for fast firmware sims.
module key_input_cond
  import key_input_cond_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NUM_KEYS-1:0] i_keys_raw,
  output logic [NUM_KEYS-1:0] o_keys_level,
  output logic [NUM_KEYS-1:0] o_keys_press,
  output logic [NUM_KEYS-1:0] o_keys_release,
  output logic                o_any_press
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("key_input_cond: DEBOUNCE_CYCLES must be >= 2");
  end

  logic [NUM_KEYS-1:0] w_press_nxt;
  logic                r_any_press;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_cell (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_key_raw   (i_keys_raw[k]),
      .o_level     (o_keys_level[k]),
      .o_press     (o_keys_press[k]),
      .o_release   (o_keys_release[k]),
      .o_press_nxt (w_press_nxt[k])
    );
  end

  // Registered from the cells' next-press terms so it lines up with o_keys_press.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_any_press <= 1'b0;
    end else begin
      r_any_press <= |w_press_nxt;
    end
  end

  assign o_any_press = r_any_press;

endmodule

// File: tb/tb_key_input_cond.sv
// Scoreboard bench for key_input_cond: run-length reference model, per-cycle output compare.
module tb_key_input_cond;
  import key_input_cond_pkg::*;

  localparam int NK = 4;
  localparam int DB = DEBOUNCE_CYCLES_SIM;

  typedef struct packed {
    logic [NK-1:0] lvl;
    logic [NK-1:0] press;
    logic [NK-1:0] rel;
    logic          any;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NK-1:0] keys_raw;
  logic [NK-1:0] keys_level, keys_press, keys_release;
  logic          any_press;

  exp_t          exp_q[$];
  logic [NK-1:0] hist_q[$];
  logic [NK-1:0] m_lvl;
  int            m_run[NK];

  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc      = 0;
  string phase    = "init";

  key_input_cond #(
    .NUM_KEYS        (NK),
    .DEBOUNCE_CYCLES (DB),
    .ACTIVE_LOW      (1'b1)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_keys_raw     (keys_raw),
    .o_keys_level   (keys_level),
    .o_keys_press   (keys_press),
    .o_keys_release (keys_release),
    .o_any_press    (any_press)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [3*NK:0] act, input logic [3*NK:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got lvl/press/rel/any=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // A key's level flips once DB+1 consecutive synchronised samples disagree with it;
  // the synchroniser is a two-sample delay line that reset refills with the idle level.
  task automatic model_step(input logic rst_v, input logic [NK-1:0] raw);
    exp_t          e;
    logic [NK-1:0] s;
    e = '0;
    if (!rst_v) begin
      hist_q = '{'1, '1};
      m_lvl  = '0;
      foreach (m_run[k]) m_run[k] = 0;
    end else begin
      hist_q.push_back(raw);
      s = ~hist_q.pop_front();
      for (int k = 0; k < NK; k++) begin
        m_run[k] = (s[k] != m_lvl[k]) ? m_run[k] + 1 : 0;
        if (m_run[k] == DB + 1) begin
          m_lvl[k] = s[k];
          if (s[k]) e.press[k] = 1'b1;
          else      e.rel[k]   = 1'b1;
          m_run[k] = 0;
        end
      end
      e.lvl = m_lvl;
      e.any = |e.press;
    end
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic rst_v, input logic [NK-1:0] raw, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      rst_n    = rst_v;
      keys_raw = raw;
      model_step(rst_v, raw);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check(phase, {keys_level, keys_press, keys_release, any_press}, e);
    end
  end

  initial begin
    logic [NK-1:0] rnd_raw;
    int            hold[NK];

    rst_n    = 1'b0;
    keys_raw = '1;
    hist_q   = '{'1, '1};
    m_lvl    = '0;
    foreach (m_run[k]) m_run[k] = 0;

    phase = "reset";
    drive(1'b0, 4'hF, 4);
    phase = "idle_all_released";
    drive(1'b1, 4'hF, 20);

    phase = "key0_press";
    drive(1'b1, 4'hE, 15);

    phase = "key1_bounce";
    drive(1'b1, 4'hC, 5);
    drive(1'b1, 4'hE, 1);
    drive(1'b1, 4'hC, 15);

    phase = "key2_press_release";
    drive(1'b1, 4'h8, 15);
    drive(1'b1, 4'hC, 15);
    drive(1'b1, 4'hF, 15);

    phase = "key0_key3_same_edge";
    drive(1'b1, 4'h6, 15);

    phase = "reset_mid_count";
    drive(1'b1, 4'h4, 7);
    drive(1'b0, 4'h4, 1);
    #1;
    check("async_reset_clear", {keys_level, keys_press, keys_release, any_press}, '0);
    drive(1'b0, 4'h4, 3);
    drive(1'b1, 4'h4, 15);
    drive(1'b1, 4'hF, 15);

    phase   = "random";
    rnd_raw = '1;
    foreach (hold[k]) hold[k] = 0;
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < NK; k++) begin
        if (hold[k] == 0) begin
          rnd_raw[k] = ~rnd_raw[k];
          hold[k] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, DB) : $urandom_range(DB + 1, 3 * DB);
        end else begin
          hold[k]--;
        end
      end
      drive((c >= 400 && c < 403) ? 1'b0 : 1'b1, rnd_raw, 1);
    end

    phase = "drain";
    drive(1'b1, 4'hF, 3 * DB);
    @(negedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
